tt_accum_alu: RTL
=================

Name: tt_accum_alu

Overview:
- Parametrised, registered successor to the combinational 8-bit adder top: one-cycle-latency ALU plus running accumulator.
- Takes operand pairs under a valid/ready handshake and produces sum, difference, accumulate or clear results with a carry/borrow flag.
- Sits behind the TinyTapeout top wrapper:
  - operands come from ui_in/uio_in;
  - result drives uo_out;
  - handshake and flags map onto spare uio pins.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- ACC_WIDTH, 16, accumulator width in bits (>=WIDTH).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; when low, no new transactions are accepted.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands this cycle.
- out_valid  output  1  result/flag registers hold an unconsumed result.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  registered result.
- carry  output  1  ADD carry-out / SUB borrow / ACC accumulator wrap.
- acc  output  ACC_WIDTH  current accumulator value.

Behaviour:
- Interface: one clock (clk); reset rst_n asynchronous, active-low. All state is cleared immediately on rst_n low.
- Reset values:
  - out_valid=0, result=0, carry=0, acc=0.
  - in_ready follows its combinational equation and is therefore 1 if ena=1.
- in_ready = ena & (~out_valid | out_ready). This is combinational and allows full throughput (one transaction per cycle).
- Accept = in_valid & in_ready. On accept, at the next rising edge:
  - ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: result = (a-b) mod 2^WIDTH; carry = 1 iff a<b (unsigned borrow).
  - ACC: acc_next = acc + zero-extended a (ACC_WIDTH bits). Then acc=acc_next, result = acc_next[WIDTH-1:0], carry = 1 iff the addition wrapped past 2^ACC_WIDTH-1. b is ignored.
  - CLR: acc=0, result=0, carry=0.
  - out_valid=1.
- Latency: exactly 1 cycle from accept to out_valid.
- Output states:
  - EMPTY (out_valid=0) -> FULL on accept.
  - FULL & out_ready & ~accept -> EMPTY.
  - FULL & out_ready & accept -> FULL with the new result (back-to-back).
  - FULL & ~out_ready -> FULL; result, carry and acc are held stable, in_ready=0.
- acc changes only on ACC or CLR accepts. ADD and SUB never modify acc.
- ena low: in_ready=0, no accepts. A pending output still drains on out_ready.
- in_valid with in_ready=0: the operands are not captured. The source must hold them until accepted.
- Reset mid-transaction: any pending result is discarded; acc returns to 0.
- mode is sampled only on accept.

Optional Feature:
- Macro: TT_ACCUM_SATURATE_EN.
- Defined (saturating arithmetic):
  - ADD overflow -> result = 2^WIDTH-1.
  - SUB underflow -> result = 0.
  - ACC overflow -> acc = 2^ACC_WIDTH-1, and result = low WIDTH bits of that saturated value.
  - carry still reports the overflow/underflow event.
- Undefined: wrap-around arithmetic exactly as described in Behaviour.

Test Plan:
- Reset with out_ready=1, then ADD a=8'h30, b=8'h12 -> next cycle out_valid=1, result=8'h42, carry=0; then ADD 8'hF0+8'h20 -> result=8'h10, carry=1 (saturating build: 8'hFF, carry=1).
- SUB a=5, b=9 -> result=8'hFC, carry=1 (saturating build: 8'h00, carry=1); SUB 9-5 -> result=4, carry=0.
- ACC sequence a=200,100,50 with out_ready=1 every cycle -> acc=200, 300, 350 on consecutive cycles; result=8'hC8, 8'h2C, 8'h5E; carry=0. Then CLR -> acc=0, result=0.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, and result stays stable for 5 cycles while a changes; raise out_ready with in_valid=1 -> old result consumed and new result registered on the same edge.
- ACC wrap: preload acc=16'hFFF0 via ACC operations, then ACC a=8'h20 -> acc=16'h0010, carry=1 (saturating build: acc=16'hFFFF, result=8'hFF, carry=1).
- Assert rst_n low mid-stream while out_valid=1 and acc=300 -> immediately out_valid=0, acc=0, result=0. ena=0 with in_valid=1 -> in_ready=0 and no state change.

Source files
------------

// File: rtl/tt_accum_alu.sv
// rtl/tt_accum_alu.sv - registered ALU with running accumulator behind a valid/ready handshake
//
// Purpose:
//   Accepts an operand pair plus an operation code under a valid/ready
//   handshake. One cycle after the accept it presents a registered result and
//   a carry/borrow/wrap flag. A running accumulator is updated by ACC and
//   reset by CLR. The output register can take a new result on the same edge
//   that the previous one is consumed, so the block sustains one transaction
//   per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all state
//   ena        block enable; when low, no new operands are accepted
//   a, b       WIDTH-bit operands (b is ignored by ACC and CLR)
//   mode       00 ADD, 01 SUB, 10 ACC, 11 CLR
//   in_valid   operands/mode valid
//   in_ready   block can accept operands this cycle (combinational)
//   out_valid  result/carry hold an unconsumed result
//   out_ready  consumer takes the result this cycle
//   result     registered WIDTH-bit result
//   carry      ADD carry-out, SUB borrow, ACC accumulator wrap
//   acc        current ACC_WIDTH-bit accumulator value
//
// Configuration:
//   TT_ACCUM_SATURATE_EN  when defined, ADD/SUB/ACC saturate instead of
//                         wrapping; carry still flags the overflow event.

module tt_accum_alu #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic [ACC_WIDTH-1:0] acc
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [WIDTH-1:0]     result_nxt;
  logic                 carry_nxt;
  logic [ACC_WIDTH-1:0] acc_nxt;

  // A full output register may still accept when it is being drained on
  // this same edge.
  assign in_ready = ena & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // One extra bit on each datapath captures carry/borrow/wrap. For the
  // subtraction the top bit of the (WIDTH+1)-bit difference is the borrow.
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign acc_sum  = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, a};

  always_comb begin
    result_nxt = '0;
    carry_nxt  = 1'b0;
    acc_nxt    = acc;
    case (mode)
      MODE_ADD: begin
        result_nxt = add_sum[WIDTH-1:0];
        carry_nxt  = add_sum[WIDTH];
`ifdef TT_ACCUM_SATURATE_EN
        if (add_sum[WIDTH]) result_nxt = '1;
`endif
      end
      MODE_SUB: begin
        result_nxt = sub_diff[WIDTH-1:0];
        carry_nxt  = sub_diff[WIDTH];
`ifdef TT_ACCUM_SATURATE_EN
        if (sub_diff[WIDTH]) result_nxt = '0;
`endif
      end
      MODE_ACC: begin
        acc_nxt   = acc_sum[ACC_WIDTH-1:0];
        carry_nxt = acc_sum[ACC_WIDTH];
`ifdef TT_ACCUM_SATURATE_EN
        if (acc_sum[ACC_WIDTH]) acc_nxt = '1;
`endif
        result_nxt = acc_nxt[WIDTH-1:0];
      end
      MODE_CLR: begin
        acc_nxt = '0;
      end
      default: begin
        acc_nxt = acc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= result_nxt;
      carry     <= carry_nxt;
      acc       <= acc_nxt;
    end else if (out_ready) begin
      // Drained with nothing new: result/carry keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule
